// File: rtl/pipelined_dadda_mac_if.sv
// Operand/result stream bundle for pipelined_dadda_mac.
// The master side feeds operands and consumes results; the slave side is the MAC.
interface pipelined_dadda_mac_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, signed_mode, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, signed_mode, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/pipelined_dadda_mac.sv
// Pipelined multiply-accumulate: Dadda-tree product register followed by a
// framed dot-product accumulator with optional saturation and valid/ready
// flow control on both sides.
module pipelined_dadda_mac #(
  parameter int WIDTH    = 8,
  parameter int ACC_W    = 20,
  parameter bit SATURATE = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  pipelined_dadda_mac_if.slave bus
);
  localparam int PW     = 2 * WIDTH;
  localparam int MAXH   = WIDTH + 2;
  localparam int NSTAGE = 10;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic             out_valid;
  logic             stall, accept, take2;
  logic             mode_eff;
  logic             in_first_q, in_first_d;
  logic             in_mode_q, in_mode_d;
  logic             v1_q, v1_d;
  logic             last1_q, last1_d;
  logic             mode1_q, mode1_d;
  logic [PW-1:0]    p1_q, p1_d;
  logic [PW-1:0]    product;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] ext, base, res;
  logic [ACC_W:0]   sum;
  logic             ovf_new, ovf_base;

  // Dadda heights: 2,3,4,6,9,13,... (each is floor(1.5 * previous)).
  function automatic int dadda_d(input int s);
    int d = 2;
    for (int unsigned i = 0; i < s; i++) d = (d * 3) / 2;
    return d;
  endfunction

  assign stall        = out_valid & ~bus.out_ready;
  assign accept       = bus.in_valid & ~stall;
  assign take2        = v1_q & ~stall;
  assign bus.in_ready = ~stall;
  assign bus.out_acc  = acc_q;
  assign bus.out_ovf  = ovf_q;
  assign bus.out_valid = out_valid;

  // Operand mode is taken from the first term of a frame and held for the rest.
  assign mode_eff = in_first_q ? bus.signed_mode : in_mode_q;

  // Baugh-Wooley partial products reduced by a Dadda column-compression tree.
  // Signed mode inverts the rows/columns touching an operand MSB and injects
  // constant ones at columns WIDTH and 2*WIDTH-1; the final two rows meet in one adder.
  always_comb begin : dadda_tree
    logic [MAXH-1:0] cur [PW];
    logic [MAXH-1:0] nxt [PW];
    int              h   [PW];
    int              nh  [PW];
    int              d, pos, tot;
    logic            inv, x0, x1, x2;
    logic [PW-1:0]   row0, row1;
    for (int unsigned c = 0; c < PW; c++) begin
      cur[c] = '0;
      nxt[c] = '0;
      h[c]   = 0;
      nh[c]  = 0;
    end
    d = 0; pos = 0; tot = 0; inv = 1'b0; x0 = 1'b0; x1 = 1'b0; x2 = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        inv = mode_eff & ((i == WIDTH - 1) ^ (j == WIDTH - 1));
        cur[i+j][h[i+j]] = (bus.in_a[j] & bus.in_b[i]) ^ inv;
        h[i+j]++;
      end
    end
    cur[WIDTH][h[WIDTH]] = mode_eff;
    h[WIDTH]++;
    cur[PW-1][h[PW-1]] = mode_eff;
    h[PW-1]++;
    for (int unsigned s = NSTAGE; s > 0; s--) begin
      d = dadda_d(int'(s) - 1);
      for (int unsigned c = 0; c < PW; c++) begin
        nxt[c] = '0;
        nh[c]  = 0;
      end
      for (int unsigned c = 0; c < PW; c++) begin
        pos = 0;
        for (int unsigned it = 0; it < MAXH; it++) begin
          tot = (h[c] - pos) + nh[c];
          if (tot > d && (h[c] - pos) >= 3 && (tot - d) >= 2) begin
            x0 = cur[c][pos]; x1 = cur[c][pos+1]; x2 = cur[c][pos+2];
            nxt[c][nh[c]] = x0 ^ x1 ^ x2;
            nh[c]++;
            if (c + 1 < PW) begin
              nxt[c+1][nh[c+1]] = (x0 & x1) | (x0 & x2) | (x1 & x2);
              nh[c+1]++;
            end
            pos += 3;
          end else if (tot > d && (h[c] - pos) >= 2) begin
            x0 = cur[c][pos]; x1 = cur[c][pos+1];
            nxt[c][nh[c]] = x0 ^ x1;
            nh[c]++;
            if (c + 1 < PW) begin
              nxt[c+1][nh[c+1]] = x0 & x1;
              nh[c+1]++;
            end
            pos += 2;
          end
        end
        for (int unsigned k = 0; k < MAXH; k++) begin
          if (int'(k) >= pos && int'(k) < h[c]) begin
            nxt[c][nh[c]] = cur[c][k];
            nh[c]++;
          end
        end
      end
      cur = nxt;
      h   = nh;
    end
    for (int unsigned c = 0; c < PW; c++) begin
      row0[c] = (h[c] > 0) ? cur[c][0] : 1'b0;
      row1[c] = (h[c] > 1) ? cur[c][1] : 1'b0;
    end
    product = row0 + row1;
  end

  // Stage 1 next-state: capture product on accept, bubble when idle, hold on stall.
  always_comb begin
    v1_d       = v1_q;
    p1_d       = p1_q;
    last1_d    = last1_q;
    mode1_d    = mode1_q;
    in_first_d = in_first_q;
    in_mode_d  = in_mode_q;
    if (!stall) begin
      v1_d = accept;
      if (accept) begin
        p1_d       = product;
        last1_d    = bus.in_last;
        mode1_d    = mode_eff;
        in_first_d = bus.in_last;
        in_mode_d  = mode_eff;
      end
    end
  end

  // Stage 2 arithmetic: extend product, add to base, detect and optionally clamp overflow.
  always_comb begin
    ext      = mode1_q ? ACC_W'($signed(p1_q)) : ACC_W'(p1_q);
    base     = (state_q == ACCUM) ? acc_q : '0;
    ovf_base = (state_q == ACCUM) ? ovf_q : 1'b0;
    sum      = {1'b0, base} + {1'b0, ext};
    res      = sum[ACC_W-1:0];
    if (mode1_q)
      ovf_new = (base[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
    else
      ovf_new = sum[ACC_W];
    if (SATURATE && ovf_new) begin
      if (!mode1_q)           res = '1;
      else if (base[ACC_W-1]) res = {1'b1, {(ACC_W-1){1'b0}}};
      else                    res = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // FSM next state: a term closing a frame goes to HOLD; HOLD drains on out_ready
  // and may absorb the first term of the next frame on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: if (take2) state_d = last1_q ? HOLD : ACCUM;
      HOLD: begin
        if (bus.out_ready) begin
          if (take2) state_d = last1_q ? HOLD : ACCUM;
          else       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulator/overflow update; consuming a result with no new term clears them.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (take2) begin
      acc_d = res;
      ovf_d = ovf_base | ovf_new;
    end else if (state_q == HOLD && bus.out_ready) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  // FSM outputs.
  always_comb begin
    out_valid = (state_q == HOLD);
  end

  // All pipeline and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_first_q <= 1'b1;
      in_mode_q  <= 1'b0;
      v1_q       <= 1'b0;
      p1_q       <= '0;
      last1_q    <= 1'b0;
      mode1_q    <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_first_q <= in_first_d;
      in_mode_q  <= in_mode_d;
      v1_q       <= v1_d;
      p1_q       <= p1_d;
      last1_q    <= last1_d;
      mode1_q    <= mode1_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end
endmodule

// File: tb/tb_pipelined_dadda_mac.sv
// Directed bench for pipelined_dadda_mac: a 20-bit saturating instance plus
// 16-bit saturating and wrapping instances for overflow corners.
module tb_pipelined_dadda_mac;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipelined_dadda_mac_if #(.WIDTH(8), .ACC_W(20)) b20 ();
  pipelined_dadda_mac_if #(.WIDTH(8), .ACC_W(16)) b16s ();
  pipelined_dadda_mac_if #(.WIDTH(8), .ACC_W(16)) b16w ();

  pipelined_dadda_mac #(.WIDTH(8), .ACC_W(20), .SATURATE(1'b1)) u20 (
    .clk(clk), .rst_n(rst_n), .bus(b20));
  pipelined_dadda_mac #(.WIDTH(8), .ACC_W(16), .SATURATE(1'b1)) u16s (
    .clk(clk), .rst_n(rst_n), .bus(b16s));
  pipelined_dadda_mac #(.WIDTH(8), .ACC_W(16), .SATURATE(1'b0)) u16w (
    .clk(clk), .rst_n(rst_n), .bus(b16w));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [19:0] exp_acc;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive20(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic last, input logic sm);
    b20.in_valid = v; b20.in_a = a; b20.in_b = b; b20.in_last = last; b20.signed_mode = sm;
  endtask

  task automatic drive16(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic last, input logic sm);
    b16s.in_valid = v; b16s.in_a = a; b16s.in_b = b; b16s.in_last = last; b16s.signed_mode = sm;
    b16w.in_valid = v; b16w.in_a = a; b16w.in_b = b; b16w.in_last = last; b16w.signed_mode = sm;
  endtask

  // One-term frame: result must appear on the second edge counted from the accept edge.
  task automatic run_single(input string nm, input logic [7:0] a, input logic [7:0] b,
                            input logic sm, input logic [19:0] exp);
    drive20(1'b1, a, b, 1'b1, sm);
    tick();
    drive20(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check({nm, "_early_valid"}, 32'(b20.out_valid), 32'd0);
    tick();
    check({nm, "_valid"}, 32'(b20.out_valid), 32'd1);
    check({nm, "_acc"}, 32'(b20.out_acc), 32'(exp));
    check({nm, "_ovf"}, 32'(b20.out_ovf), 32'd0);
  endtask

  initial begin
    tbl[0] = '{8'd255, 8'd255, 1'b0, 20'd65025};
    tbl[1] = '{8'hFF,  8'hFF,  1'b1, 20'd1};
    tbl[2] = '{8'h80,  8'h80,  1'b1, 20'h04000};
    tbl[3] = '{8'h80,  8'h7F,  1'b1, 20'hFC080};
    tbl[4] = '{8'h7F,  8'h7F,  1'b1, 20'd16129};
    tbl[5] = '{8'h01,  8'h80,  1'b1, 20'hFFF80};
    tbl[6] = '{8'd200, 8'd3,   1'b0, 20'd600};
    tbl[7] = '{8'h00,  8'hAB,  1'b1, 20'd0};
    tbl[8] = '{8'h80,  8'hFF,  1'b0, 20'd32640};
    tbl[9] = '{8'hFB,  8'h03,  1'b1, 20'hFFFF1};

    drive20(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive16(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    b20.out_ready = 1'b1; b16s.out_ready = 1'b1; b16w.out_ready = 1'b1;

    #12;
    check("rst_valid", 32'(b20.out_valid), 32'd0);
    check("rst_acc", 32'(b20.out_acc), 32'd0);
    check("rst_ovf", 32'(b20.out_ovf), 32'd0);
    check("rst_ready", 32'(b20.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single-term frames, signed and unsigned
    for (int i = 0; i < 10; i++)
      run_single($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].exp_acc);

    // signed three-term frame
    drive20(1'b1, 8'h80, 8'h80, 1'b0, 1'b1); tick();
    drive20(1'b1, 8'h80, 8'h7F, 1'b0, 1'b1); tick();
    drive20(1'b1, 8'd3,  8'hFB, 1'b1, 1'b1); tick();
    drive20(1'b0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    check("sframe_valid", 32'(b20.out_valid), 32'd1);
    check("sframe_acc", 32'(b20.out_acc), 32'h00071);
    check("sframe_ovf", 32'(b20.out_ovf), 32'd0);

    // mode flip on second term is ignored: 255*2 + 255*255 unsigned
    drive20(1'b1, 8'hFF, 8'd2,  1'b0, 1'b0); tick();
    drive20(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1); tick();
    drive20(1'b0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    check("modeflip_acc", 32'(b20.out_acc), 32'd65535);
    check("modeflip_ovf", 32'(b20.out_ovf), 32'd0);

    // back-to-back one-term frames
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive20(1'b1, 8'(i + 1), 8'(i + 1), 1'b1, 1'b0);
      else       drive20(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      tick();
      if (i >= 1) begin
        check($sformatf("stream%0d_valid", i), 32'(b20.out_valid), 32'd1);
        check($sformatf("stream%0d_acc", i), 32'(b20.out_acc), 32'(i * i));
      end
    end
    tick();

    // backpressure
    b20.out_ready = 1'b0;
    drive20(1'b1, 8'd5, 8'd6, 1'b1, 1'b0); tick();
    drive20(1'b0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    check("bp_valid", 32'(b20.out_valid), 32'd1);
    check("bp_acc", 32'(b20.out_acc), 32'd30);
    check("bp_in_ready", 32'(b20.in_ready), 32'd0);
    drive20(1'b1, 8'd7, 8'd7, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("bp_hold%0d_valid", i), 32'(b20.out_valid), 32'd1);
      check($sformatf("bp_hold%0d_acc", i), 32'(b20.out_acc), 32'd30);
    end
    b20.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(b20.in_ready), 32'd1);
    tick();
    drive20(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("bp_drain_valid", 32'(b20.out_valid), 32'd0);
    tick();
    check("bp_next_valid", 32'(b20.out_valid), 32'd1);
    check("bp_next_acc", 32'(b20.out_acc), 32'd49);
    tick();

    // reset in the middle of a frame
    drive20(1'b1, 8'd10, 8'd10, 1'b0, 1'b0); tick();
    drive20(1'b1, 8'd20, 8'd20, 1'b0, 1'b0); tick();
    drive20(1'b0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(b20.out_valid), 32'd0);
    check("midrst_acc", 32'(b20.out_acc), 32'd0);
    check("midrst_ovf", 32'(b20.out_ovf), 32'd0);
    check("midrst_ready", 32'(b20.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_single("postrst", 8'd2, 8'd3, 1'b0, 20'd6);
    tick();

    // ACC_W=16 unsigned overflow: saturate vs wrap
    drive16(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0); tick();
    drive16(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0); tick();
    drive16(1'b0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    check("u16_sat_acc", 32'(b16s.out_acc), 32'd65535);
    check("u16_sat_ovf", 32'(b16s.out_ovf), 32'd1);
    check("u16_wrap_acc", 32'(b16w.out_acc), 32'd64514);
    check("u16_wrap_ovf", 32'(b16w.out_ovf), 32'd1);

    // ACC_W=16 signed overflow then continue from clamped/wrapped value
    drive16(1'b1, 8'h80, 8'h80, 1'b0, 1'b1); tick();
    drive16(1'b1, 8'h80, 8'h80, 1'b0, 1'b1); tick();
    drive16(1'b1, 8'hFF, 8'h01, 1'b1, 1'b1); tick();
    drive16(1'b0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    check("s16_sat_acc", 32'(b16s.out_acc), 32'h7FFE);
    check("s16_sat_ovf", 32'(b16s.out_ovf), 32'd1);
    check("s16_wrap_acc", 32'(b16w.out_acc), 32'h7FFF);
    check("s16_wrap_ovf", 32'(b16w.out_ovf), 32'd1);

    // sticky overflow cleared once its frame is consumed
    drive16(1'b1, 8'd1, 8'd1, 1'b1, 1'b0); tick();
    drive16(1'b0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    check("clr_sat_acc", 32'(b16s.out_acc), 32'd1);
    check("clr_sat_ovf", 32'(b16s.out_ovf), 32'd0);
    check("clr_wrap_ovf", 32'(b16w.out_ovf), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
